// File: rtl/alu_iq_pkg.sv
// Shared widths and the issue-queue entry layout for alu_issue_queue.
// Every slot carries the ALU payload, both source tags and their ready bits.
package alu_iq_pkg;

  localparam int CNTRL_SIZE = 7;
  localparam int NCOMMIT    = 32;
  localparam int LNCOMMIT   = 5;
  localparam int VA_SZ      = 48;
  localparam int NHART      = 1;
  localparam int LNHART     = $clog2(NHART);
  localparam int HART_W     = (LNHART >= 1) ? LNHART : 1;

  typedef struct packed {
    logic [CNTRL_SIZE-1:0] control;
    logic [LNCOMMIT-1:0]   rd;
    logic                  makes_rd;
    logic                  needs_rs2;
    logic [VA_SZ-2:0]      pc;
    logic [31:0]           immed;
    logic [HART_W-1:0]     hart;
    logic                  rv32;
    logic [LNCOMMIT-1:0]   rs1;
    logic [LNCOMMIT-1:0]   rs2;
    logic                  rs1_rdy;
    logic                  rs2_rdy;
  } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup, kill and ALU-issue bundle around alu_issue_queue.
// The master side feeds the queue; the slave side is the queue itself.
interface alu_issue_queue_if import alu_iq_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int NWAKE = 2
);

  logic                      disp_valid;
  logic                      disp_ready;
  logic [CNTRL_SIZE-1:0]     disp_control;
  logic [LNCOMMIT-1:0]       disp_rd;
  logic                      disp_makes_rd;
  logic                      disp_needs_rs2;
  logic [VA_SZ-2:0]          disp_pc;
  logic [31:0]               disp_immed;
  logic [HART_W-1:0]         disp_hart;
  logic                      disp_rv32;
  logic [LNCOMMIT-1:0]       disp_rs1;
  logic [LNCOMMIT-1:0]       disp_rs2;
  logic                      disp_rs1_rdy;
  logic                      disp_rs2_rdy;

  logic [NWAKE-1:0]          wake_valid;
  logic [NWAKE*LNCOMMIT-1:0] wake_tag;
  logic [NCOMMIT-1:0]        commit_kill;

  logic                      enable;
  logic [CNTRL_SIZE-1:0]     control;
  logic [LNCOMMIT-1:0]       rd;
  logic                      makes_rd;
  logic                      needs_rs2;
  logic [VA_SZ-2:0]          pc;
  logic [31:0]               immed;
  logic [HART_W-1:0]         hart;
  logic                      rv32;
  logic [LNCOMMIT-1:0]       rs1_tag;
  logic [LNCOMMIT-1:0]       rs2_tag;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output disp_valid, disp_control, disp_rd, disp_makes_rd, disp_needs_rs2,
           disp_pc, disp_immed, disp_hart, disp_rv32, disp_rs1, disp_rs2,
           disp_rs1_rdy, disp_rs2_rdy, wake_valid, wake_tag, commit_kill,
    input  disp_ready, enable, control, rd, makes_rd, needs_rs2, pc, immed,
           hart, rv32, rs1_tag, rs2_tag, count
  );

  modport slave (
    input  disp_valid, disp_control, disp_rd, disp_makes_rd, disp_needs_rs2,
           disp_pc, disp_immed, disp_hart, disp_rv32, disp_rs1, disp_rs2,
           disp_rs1_rdy, disp_rs2_rdy, wake_valid, wake_tag, commit_kill,
    output disp_ready, enable, control, rd, makes_rd, needs_rs2, pc, immed,
           hart, rv32, rs1_tag, rs2_tag, count
  );

endinterface

// File: rtl/alu_iq_entry.sv
// One issue-queue slot: the stored entry, its wakeup comparators and kill lookup.
// `entry` exposes the stored op with this cycle's wakeups already merged in.
module alu_iq_entry import alu_iq_pkg::*; #(
  parameter int NWAKE = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      next_valid,
  input  iq_entry_t                 next_entry,
  input  logic [NWAKE-1:0]          wake_valid,
  input  logic [NWAKE*LNCOMMIT-1:0] wake_tag,
  input  logic [NCOMMIT-1:0]        commit_kill,
  output logic                      valid,
  output iq_entry_t                 entry,
  output logic                      ready,
  output logic                      killed
);

  iq_entry_t state;
  logic      hit1;
  logic      hit2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      state <= '0;
    end else begin
      valid <= next_valid;
      state <= next_entry;
    end
  end

  // Selection uses only the registered ready bits, so a wake takes one edge to matter.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int w = 0; w < NWAKE; w++) begin
      if (wake_valid[w] && (wake_tag[w*LNCOMMIT +: LNCOMMIT] == state.rs1)) hit1 = 1'b1;
      if (wake_valid[w] && (wake_tag[w*LNCOMMIT +: LNCOMMIT] == state.rs2)) hit2 = 1'b1;
    end
    entry         = state;
    entry.rs1_rdy = state.rs1_rdy | hit1;
    entry.rs2_rdy = state.rs2_rdy | hit2;
    killed        = valid & commit_kill[state.rd];
    ready         = valid & state.rs1_rdy & state.rs2_rdy & ~commit_kill[state.rd];
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing issue queue in front of alu: oldest-ready select, registered issue,
// and a compaction network that removes issued/killed slots and appends dispatch.
module alu_issue_queue import alu_iq_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int NWAKE = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_issue_queue_if.slave io
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] killed;
  logic [DEPTH-1:0] next_valid;
  iq_entry_t        entry      [DEPTH];
  iq_entry_t        next_entry [DEPTH];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] pos;
  logic             disp_ready;
  logic             disp_fire;
  logic             disp_hit1;
  logic             disp_hit2;
  iq_entry_t        disp_entry;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    alu_iq_entry #(.NWAKE(NWAKE)) u_entry (
      .clk         (clk),
      .reset       (reset),
      .next_valid  (next_valid[i]),
      .next_entry  (next_entry[i]),
      .wake_valid  (io.wake_valid),
      .wake_tag    (io.wake_tag),
      .commit_kill (io.commit_kill),
      .valid       (valid[i]),
      .entry       (entry[i]),
      .ready       (ready[i]),
      .killed      (killed[i])
    );
  end

  assign disp_ready    = (count_q < FULL);
  assign io.disp_ready = disp_ready;
  assign io.count      = count_q;

  // Incoming op picks up any wakeup broadcast in the same cycle it arrives.
  always_comb begin
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int w = 0; w < NWAKE; w++) begin
      if (io.wake_valid[w] && (io.wake_tag[w*LNCOMMIT +: LNCOMMIT] == io.disp_rs1)) disp_hit1 = 1'b1;
      if (io.wake_valid[w] && (io.wake_tag[w*LNCOMMIT +: LNCOMMIT] == io.disp_rs2)) disp_hit2 = 1'b1;
    end
    disp_entry           = '0;
    disp_entry.control   = io.disp_control;
    disp_entry.rd        = io.disp_rd;
    disp_entry.makes_rd  = io.disp_makes_rd;
    disp_entry.needs_rs2 = io.disp_needs_rs2;
    disp_entry.pc        = io.disp_pc;
    disp_entry.immed     = io.disp_immed;
    disp_entry.hart      = io.disp_hart;
    disp_entry.rv32      = io.disp_rv32;
    disp_entry.rs1       = io.disp_rs1;
    disp_entry.rs2       = io.disp_rs2;
    disp_entry.rs1_rdy   = io.disp_rs1_rdy | disp_hit1;
    disp_entry.rs2_rdy   = ~io.disp_needs_rs2 | io.disp_rs2_rdy | disp_hit2;
    disp_fire            = io.disp_valid & disp_ready & ~io.commit_kill[io.disp_rd];
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Survivors slide down in age order; the dispatched op lands just above them.
  always_comb begin
    pos        = '0;
    next_valid = '0;
    for (int i = 0; i < DEPTH; i++) next_entry[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && !killed[i] && !(sel_found && (sel_idx == IDX_W'(i)))) begin
        if (pos < FULL) begin
          next_valid[pos[IDX_W-1:0]] = 1'b1;
          next_entry[pos[IDX_W-1:0]] = entry[i];
        end
        pos = pos + CNT_W'(1);
      end
    end
    if (disp_fire && (pos < FULL)) begin
      next_valid[pos[IDX_W-1:0]] = 1'b1;
      next_entry[pos[IDX_W-1:0]] = disp_entry;
      pos = pos + CNT_W'(1);
    end
    count_d = pos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io.enable    <= 1'b0;
      io.control   <= '0;
      io.rd        <= '0;
      io.makes_rd  <= 1'b0;
      io.needs_rs2 <= 1'b0;
      io.pc        <= '0;
      io.immed     <= '0;
      io.hart      <= '0;
      io.rv32      <= 1'b0;
      io.rs1_tag   <= '0;
      io.rs2_tag   <= '0;
    end else if (sel_found) begin
      io.enable    <= 1'b1;
      io.control   <= entry[sel_idx].control;
      io.rd        <= entry[sel_idx].rd;
      io.makes_rd  <= entry[sel_idx].makes_rd;
      io.needs_rs2 <= entry[sel_idx].needs_rs2;
      io.pc        <= entry[sel_idx].pc;
      io.immed     <= entry[sel_idx].immed;
      io.hart      <= entry[sel_idx].hart;
      io.rv32      <= entry[sel_idx].rv32;
      io.rs1_tag   <= entry[sel_idx].rs1;
      io.rs2_tag   <= entry[sel_idx].rs2;
    end else begin
      io.enable    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: ordering, wakeup, full queue, kill and reset.
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(8), .NWAKE(2)) io ();

  alu_issue_queue #(.DEPTH(8), .NWAKE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    io.disp_valid     = 1'b0;
    io.disp_control   = '0;
    io.disp_rd        = '0;
    io.disp_makes_rd  = 1'b0;
    io.disp_needs_rs2 = 1'b0;
    io.disp_pc        = '0;
    io.disp_immed     = '0;
    io.disp_hart      = '0;
    io.disp_rv32      = 1'b0;
    io.disp_rs1       = '0;
    io.disp_rs2       = '0;
    io.disp_rs1_rdy   = 1'b0;
    io.disp_rs2_rdy   = 1'b0;
    io.wake_valid     = '0;
    io.wake_tag       = '0;
    io.commit_kill    = '0;
  endtask

  // Payload fields are derived from rd so every issued op is recognisable.
  task automatic applyStimulus(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_rdy,
                               input logic needs_rs2, input logic [4:0] rs2, input logic rs2_rdy);
    io.disp_valid     = 1'b1;
    io.disp_control   = {2'b10, rd};
    io.disp_rd        = rd;
    io.disp_makes_rd  = 1'b1;
    io.disp_needs_rs2 = needs_rs2;
    io.disp_pc        = {42'd0, rd};
    io.disp_immed     = {27'h1234567, rd};
    io.disp_hart      = '0;
    io.disp_rv32      = rd[0];
    io.disp_rs1       = rs1;
    io.disp_rs2       = rs2;
    io.disp_rs1_rdy   = rs1_rdy;
    io.disp_rs2_rdy   = rs2_rdy;
  endtask

  task automatic setWake(input logic [1:0] v, input logic [9:0] tags);
    io.wake_valid = v;
    io.wake_tag   = tags;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    tick();
    tick();
    checkOutput("rst_enable",   64'(io.enable), 64'd0);
    checkOutput("rst_count",    64'(io.count), 64'd0);
    checkOutput("rst_ready",    64'(io.disp_ready), 64'd1);
    checkOutput("rst_makes_rd", 64'(io.makes_rd), 64'd0);
    checkOutput("rst_rd",       64'(io.rd), 64'd0);
    checkOutput("rst_control",  64'(io.control), 64'd0);
    reset = 1'b1;
    tick();

    $display("[TB] three ready ops in order");
    applyStimulus(5'd1, 5'd17, 1'b1, 1'b1, 5'd18, 1'b1);
    tick();
    checkOutput("t1_e0_enable", 64'(io.enable), 64'd0);
    checkOutput("t1_e0_count",  64'(io.count), 64'd1);
    applyStimulus(5'd2, 5'd17, 1'b1, 1'b1, 5'd18, 1'b1);
    tick();
    checkOutput("t1_e1_enable",  64'(io.enable), 64'd1);
    checkOutput("t1_e1_rd",      64'(io.rd), 64'd1);
    checkOutput("t1_e1_control", 64'(io.control), 64'h41);
    checkOutput("t1_e1_immed",   64'(io.immed), 64'h2468ACE1);
    checkOutput("t1_e1_pc",      64'(io.pc), 64'd1);
    checkOutput("t1_e1_rv32",    64'(io.rv32), 64'd1);
    checkOutput("t1_e1_rs1tag",  64'(io.rs1_tag), 64'd17);
    checkOutput("t1_e1_rs2tag",  64'(io.rs2_tag), 64'd18);
    checkOutput("t1_e1_count",   64'(io.count), 64'd1);
    applyStimulus(5'd3, 5'd17, 1'b1, 1'b1, 5'd18, 1'b1);
    tick();
    checkOutput("t1_e2_enable", 64'(io.enable), 64'd1);
    checkOutput("t1_e2_rd",     64'(io.rd), 64'd2);
    io.disp_valid = 1'b0;
    tick();
    checkOutput("t1_e3_enable", 64'(io.enable), 64'd1);
    checkOutput("t1_e3_rd",     64'(io.rd), 64'd3);
    checkOutput("t1_e3_count",  64'(io.count), 64'd0);
    tick();
    checkOutput("t1_e4_enable", 64'(io.enable), 64'd0);
    checkOutput("t1_e4_rd_hold", 64'(io.rd), 64'd3);

    $display("[TB] younger ready op bypasses older waiting op");
    applyStimulus(5'd5, 5'd9, 1'b0, 1'b1, 5'd10, 1'b1);
    tick();
    applyStimulus(5'd6, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("t2_count2",  64'(io.count), 64'd2);
    checkOutput("t2_enable0", 64'(io.enable), 64'd0);
    io.disp_valid = 1'b0;
    tick();
    checkOutput("t2_b_enable", 64'(io.enable), 64'd1);
    checkOutput("t2_b_rd",     64'(io.rd), 64'd6);
    checkOutput("t2_b_needs2", 64'(io.needs_rs2), 64'd0);
    setWake(2'b01, {5'd0, 5'd9});
    tick();
    checkOutput("t2_wake_edge_enable", 64'(io.enable), 64'd0);
    checkOutput("t2_wake_edge_count",  64'(io.count), 64'd1);
    setWake(2'b00, 10'd0);
    tick();
    checkOutput("t2_a_enable", 64'(io.enable), 64'd1);
    checkOutput("t2_a_rd",     64'(io.rd), 64'd5);
    checkOutput("t2_a_rs1tag", 64'(io.rs1_tag), 64'd9);
    checkOutput("t2_a_count",  64'(io.count), 64'd0);

    $display("[TB] fill queue, wake one entry");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'(8 + i), 5'(20 + i), 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    checkOutput("t3_full_count", 64'(io.count), 64'd8);
    checkOutput("t3_full_ready", 64'(io.disp_ready), 64'd0);
    applyStimulus(5'd30, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0);
    setWake(2'b01, {5'd0, 5'd23});
    tick();
    checkOutput("t3_w_count",  64'(io.count), 64'd8);
    checkOutput("t3_w_ready",  64'(io.disp_ready), 64'd0);
    checkOutput("t3_w_enable", 64'(io.enable), 64'd0);
    setWake(2'b00, 10'd0);
    tick();
    checkOutput("t3_issue_enable", 64'(io.enable), 64'd1);
    checkOutput("t3_issue_rd",     64'(io.rd), 64'd11);
    checkOutput("t3_issue_count",  64'(io.count), 64'd7);
    checkOutput("t3_issue_ready",  64'(io.disp_ready), 64'd1);
    io.disp_valid  = 1'b0;
    io.commit_kill = 32'h0000_FF00;
    tick();
    checkOutput("t3_flush_count",  64'(io.count), 64'd0);
    checkOutput("t3_flush_enable", 64'(io.enable), 64'd0);
    io.commit_kill = '0;

    $display("[TB] kill middle entry keeps order");
    applyStimulus(5'd3, 5'd16, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(5'd4, 5'd16, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(5'd7, 5'd16, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    io.disp_valid = 1'b0;
    checkOutput("t4_count3", 64'(io.count), 64'd3);
    io.commit_kill = 32'h0000_0010;
    tick();
    checkOutput("t4_kill_count", 64'(io.count), 64'd2);
    io.commit_kill = '0;
    setWake(2'b01, {5'd0, 5'd16});
    tick();
    checkOutput("t4_wake_enable", 64'(io.enable), 64'd0);
    setWake(2'b00, 10'd0);
    tick();
    checkOutput("t4_first_enable", 64'(io.enable), 64'd1);
    checkOutput("t4_first_rd",     64'(io.rd), 64'd3);
    tick();
    checkOutput("t4_second_enable", 64'(io.enable), 64'd1);
    checkOutput("t4_second_rd",     64'(io.rd), 64'd7);
    checkOutput("t4_second_count",  64'(io.count), 64'd0);
    tick();
    checkOutput("t4_done_enable", 64'(io.enable), 64'd0);

    $display("[TB] dispatch with same-cycle wake");
    applyStimulus(5'd20, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0);
    setWake(2'b10, {5'd12, 5'd0});
    tick();
    clearInputs();
    checkOutput("t5_count",  64'(io.count), 64'd1);
    checkOutput("t5_enable0", 64'(io.enable), 64'd0);
    tick();
    checkOutput("t5_enable", 64'(io.enable), 64'd1);
    checkOutput("t5_rd",     64'(io.rd), 64'd20);
    checkOutput("t5_rs1tag", 64'(io.rs1_tag), 64'd12);

    $display("[TB] asynchronous reset with pending entries");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'(21 + i), 5'd25, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    applyStimulus(5'd26, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    io.disp_valid = 1'b0;
    checkOutput("t6_count6", 64'(io.count), 64'd6);
    tick();
    checkOutput("t6_pre_enable", 64'(io.enable), 64'd1);
    checkOutput("t6_pre_rd",     64'(io.rd), 64'd26);
    checkOutput("t6_pre_count",  64'(io.count), 64'd5);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6_rst_enable", 64'(io.enable), 64'd0);
    checkOutput("t6_rst_count",  64'(io.count), 64'd0);
    checkOutput("t6_rst_ready",  64'(io.disp_ready), 64'd1);
    checkOutput("t6_rst_rd",     64'(io.rd), 64'd0);
    tick();
    reset = 1'b1;
    setWake(2'b01, {5'd0, 5'd25});
    tick();
    setWake(2'b00, 10'd0);
    checkOutput("t6_post_count",   64'(io.count), 64'd0);
    checkOutput("t6_post_enable1", 64'(io.enable), 64'd0);
    tick();
    checkOutput("t6_post_enable2", 64'(io.enable), 64'd0);
    tick();
    checkOutput("t6_post_enable3", 64'(io.enable), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
